// File: rtl/fractal_sync_np_remote_rf.sv
// fractal_sync_np_remote_rf
//   N-port counting remote register file for the fractal synchronization tree.
//   Every request names a tree node (level, id) and the number of participants
//   expected at that node. Arrivals are accumulated per node. All waiters are
//   released in the cycle the count is reached. Arrivals that hit the same
//   node in the same cycle are merged into one counter update.
//
// Ports
//   clk_i, rst_i    clock, synchronous active-high reset
//   req_valid_i[p]  one-cycle arrival strobe on port p
//   level_i[p]      tree level of the addressed node
//   id_i[p]         node id within that level
//   expected_i[p]   participants required for release
//   rsp_valid_o[p]  registered response strobe, one cycle after the request
//   rsp_release_o[p] 1 = barrier completed, 0 = still pending
//   rsp_err_o[p]    00 ok, 01 bad signature, 10 bad expected, 11 overflow
//   pending_o       number of nodes holding a nonzero count (registered)
module fractal_sync_np_remote_rf #(
  parameter int N_PORTS     = 4,
  parameter int ID_WIDTH    = 3,
  parameter int LEVEL_WIDTH = 2,
  parameter int MAX_PART    = 4,
  parameter int CNT_WIDTH   = $clog2(MAX_PART + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i   [N_PORTS],
  input  logic [LEVEL_WIDTH-1:0] level_i       [N_PORTS],
  input  logic [ID_WIDTH-1:0]    id_i          [N_PORTS],
  input  logic [CNT_WIDTH-1:0]   expected_i    [N_PORTS],
  output logic                   rsp_valid_o   [N_PORTS],
  output logic                   rsp_release_o [N_PORTS],
  output logic [1:0]             rsp_err_o     [N_PORTS],
  // N_REGS+1 == 2**(ID_WIDTH+1), so the pending count needs ID_WIDTH+1 bits
  output logic [ID_WIDTH:0]      pending_o
);

  localparam int N_REGS = 2**(ID_WIDTH+1) - 1;
  localparam int SIG_W  = ID_WIDTH + 1;
  localparam int PEND_W = ID_WIDTH + 1;

  // A node exists when its level is in range and the id fits that level.
  function automatic logic sig_ok_f(input logic [LEVEL_WIDTH-1:0] lvl,
                                    input logic [ID_WIDTH-1:0]    id);
    if (int'(lvl) > ID_WIDTH) return 1'b0;
    return (int'(id) >> (ID_WIDTH - int'(lvl))) == 0;
  endfunction

  // Flat entry index: levels are packed one after another, level 0 first.
  function automatic logic [SIG_W-1:0] sig_f(input logic [LEVEL_WIDTH-1:0] lvl,
                                             input logic [ID_WIDTH-1:0]    id);
    int base;
    if (int'(lvl) > ID_WIDTH) return '0;
    base = (1 << (ID_WIDTH + 1)) - (1 << (ID_WIDTH - int'(lvl) + 1));
    return SIG_W'(base + int'(id));
  endfunction

  logic [CNT_WIDTH-1:0] cnt_q [N_REGS];
  logic [CNT_WIDTH-1:0] cnt_d [N_REGS];
  logic                 rsp_valid_q [N_PORTS];
  logic                 rsp_valid_d [N_PORTS];
  logic                 rsp_release_q [N_PORTS];
  logic                 rsp_release_d [N_PORTS];
  logic [1:0]           rsp_err_q [N_PORTS];
  logic [1:0]           rsp_err_d [N_PORTS];
  logic [PEND_W-1:0]    pending_q;
  logic [PEND_W-1:0]    pending_d;

  // Per-port request decode
  logic [SIG_W-1:0] sig      [N_PORTS];
  logic [1:0]       err_code [N_PORTS];
  logic             good     [N_PORTS];

  genvar gi;
  generate
    for (gi = 0; gi < N_PORTS; gi++) begin : g_decode
      logic sig_good;
      logic exp_good;
      assign sig_good = sig_ok_f(level_i[gi], id_i[gi]);
      assign exp_good = (expected_i[gi] != '0) && (int'(expected_i[gi]) <= MAX_PART);
      assign sig[gi]  = sig_f(level_i[gi], id_i[gi]);
      // Bad signature outranks bad expected
      assign err_code[gi] = !sig_good ? 2'b01 : (!exp_good ? 2'b10 : 2'b00);
      assign good[gi]     = req_valid_i[gi] && sig_good && exp_good;
    end
  endgenerate

  int   k_v;
  int   e_v;
  int   sum_v;
  int   pend_v;
  logic lead_v;

  always_comb begin
    for (int r = 0; r < N_REGS; r++) cnt_d[r] = cnt_q[r];
    k_v    = 0;
    e_v    = 0;
    sum_v  = 0;
    pend_v = 0;
    lead_v = 1'b0;

    for (int p = 0; p < N_PORTS; p++) begin
      rsp_valid_d[p]   = req_valid_i[p];
      rsp_release_d[p] = 1'b0;
      rsp_err_d[p]     = req_valid_i[p] ? err_code[p] : 2'b00;

      if (good[p]) begin
        // Every port of a group recomputes the same group result, so the
        // repeated writes to cnt_d carry identical values.
        k_v    = 0;
        e_v    = 0;
        lead_v = 1'b0;
        for (int q = 0; q < N_PORTS; q++) begin
          if (good[q] && sig[q] == sig[p]) begin
            k_v = k_v + 1;
            if (!lead_v) begin
              e_v    = int'(expected_i[q]);
              lead_v = 1'b1;
            end
          end
        end
        sum_v = int'(cnt_q[sig[p]]) + k_v;
        if (sum_v < e_v) begin
          cnt_d[sig[p]] = CNT_WIDTH'(sum_v);
        end else begin
          cnt_d[sig[p]]    = '0;
          rsp_release_d[p] = 1'b1;
          if (sum_v > e_v) rsp_err_d[p] = 2'b11;
        end
      end
    end

    for (int r = 0; r < N_REGS; r++) begin
      if (cnt_d[r] != '0) pend_v = pend_v + 1;
    end
    pending_d = PEND_W'(pend_v);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < N_REGS; r++) cnt_q[r] <= '0;
      for (int p = 0; p < N_PORTS; p++) begin
        rsp_valid_q[p]   <= 1'b0;
        rsp_release_q[p] <= 1'b0;
        rsp_err_q[p]     <= 2'b00;
      end
      pending_q <= '0;
    end else begin
      for (int r = 0; r < N_REGS; r++) cnt_q[r] <= cnt_d[r];
      for (int p = 0; p < N_PORTS; p++) begin
        rsp_valid_q[p]   <= rsp_valid_d[p];
        rsp_release_q[p] <= rsp_release_d[p];
        rsp_err_q[p]     <= rsp_err_d[p];
      end
      pending_q <= pending_d;
    end
  end

  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_release_o = rsp_release_q;
  assign rsp_err_o     = rsp_err_q;
  assign pending_o     = pending_q;

endmodule
